// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_port serial output peripheral:
//   - uart_state_t : shifter FSM state encoding
//   - STAT_*       : bit positions inside the status byte
//   - even_parity  : even parity over one data byte
// Optional feature macro used by the importing files: UART_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   // Even parity: the parity bit makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Byte FIFO with synchronous push/pop and a combinational head output.
// Ports:
//   clk      in   rising-edge clock
//   resetBar in   asynchronous active-low reset
//   i_push   in   push i_data (ignored when full)
//   i_pop    in   pop the head (ignored when empty)
//   i_data   in   8-bit write data
//   o_data   out  8-bit head of FIFO
//   o_empty  out  FIFO holds no entries
//   o_full   out  FIFO holds DEPTH entries
//   o_count  out  number of entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetBar,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [7:0]                 i_data,
   output logic [7:0]                 o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == {CW{1'b0}});
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_port.sv
// -----------------------------------------------------------------------------
// uart_port
// Memory-mapped 8N1 serial transmitter on the nic8 data-memory bus.
//   write BASE   : queue a byte (dropped and overflow flagged when full)
//   write BASE+1 : clear overflow
//   read  BASE   : FIFO count;  read BASE+1 : {4'b0, ovf, busy, full, empty}
// Ports:
//   clk, resetBar       clock, asynchronous active-low reset
//   addr, dataIn        bus address and write data
//   storeMemBar         active-low write strobe sampled at rising clk
//   assertRam           read enable
//   dataOut, select     combinational read data and bus-drive select
//   txd                 registered serial output, idle high
// Optional feature: define UART_PARITY_EN to add an even parity bit (11-bit frame).
// -----------------------------------------------------------------------------
module uart_port
   import uart_pkg::*;
#(
   parameter logic [7:0] BASE    = 8'hFE,
   parameter int         DIVISOR = 4,
   parameter int         DEPTH   = 4
) (
   input  logic       clk,
   input  logic       resetBar,
   input  logic [7:0] addr,
   input  logic [7:0] dataIn,
   input  logic       storeMemBar,
   input  logic       assertRam,
   output logic [7:0] dataOut,
   output logic       select,
   output logic       txd
);

   localparam int         CW        = $clog2(DEPTH) + 1;
   localparam int         BW        = $clog2(DIVISOR);
   localparam logic [BW-1:0] CNT_MAX = BW'(DIVISOR - 1);
   localparam logic [7:0] STAT_ADDR = BASE + 8'd1;

   uart_state_t   r_state;
   logic [BW-1:0] r_bit_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
`ifdef UART_PARITY_EN
   logic          r_par;
`endif
   logic          r_txd;
   logic          r_ovf;

   logic          w_wr_data;
   logic          w_wr_stat;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [7:0]    w_head;
   logic [7:0]    w_status;

   assign w_wr_data = !storeMemBar && (addr == BASE);
   assign w_wr_stat = !storeMemBar && (addr == STAT_ADDR);
   // Full is judged before the edge, so a same-cycle pop never rescues the byte.
   assign w_push    = w_wr_data && !w_full;
   assign select    = assertRam && ((addr == BASE) || (addr == STAT_ADDR));
   assign txd       = r_txd;

   uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .resetBar (resetBar),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_data   (dataIn),
      .o_data   (w_head),
      .o_empty  (w_empty),
      .o_full   (w_full),
      .o_count  (w_count)
   );

   // Shifter takes a byte when idle, or at the last clock of STOP for gapless frames.
   always_comb begin
      w_pop = 1'b0;
      if ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_bit_cnt == {BW{1'b0}}))) begin
         w_pop = !w_empty;
      end else begin
         w_pop = 1'b0;
      end
   end

   // Status byte assembly and read mux.
   always_comb begin
      w_status             = 8'h00;
      w_status[STAT_EMPTY] = w_empty;
      w_status[STAT_FULL]  = w_full;
      w_status[STAT_BUSY]  = (r_state != ST_IDLE);
      w_status[STAT_OVF]   = r_ovf;
      if (!select) begin
         dataOut = 8'h00;
      end else if (addr == BASE) begin
         dataOut = {{(8 - CW){1'b0}}, w_count};
      end else begin
         dataOut = w_status;
      end
   end

   // Sticky overflow flag.
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         r_ovf <= 1'b0;
      end else if (w_wr_data && w_full) begin
         r_ovf <= 1'b1;
      end else if (w_wr_stat) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   // Shifter FSM; txd is registered and always set to the level of the state being entered.
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= {BW{1'b0}};
         r_idx     <= 3'd0;
         r_shift   <= 8'h00;
`ifdef UART_PARITY_EN
         r_par     <= 1'b0;
`endif
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_shift   <= w_head;
`ifdef UART_PARITY_EN
                  r_par     <= even_parity(w_head);
`endif
                  r_bit_cnt <= CNT_MAX;
                  r_state   <= ST_START;
                  r_txd     <= 1'b0;
               end else begin
                  r_txd     <= 1'b1;
               end
            end
            ST_START: begin
               if (r_bit_cnt != {BW{1'b0}}) begin
                  r_bit_cnt <= r_bit_cnt - BW'(1);
               end else begin
                  r_bit_cnt <= CNT_MAX;
                  r_idx     <= 3'd0;
                  r_state   <= ST_DATA;
                  r_txd     <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (r_bit_cnt != {BW{1'b0}}) begin
                  r_bit_cnt <= r_bit_cnt - BW'(1);
               end else if (r_idx == 3'd7) begin
                  r_bit_cnt <= CNT_MAX;
`ifdef UART_PARITY_EN
                  r_state   <= ST_PARITY;
                  r_txd     <= r_par;
`else
                  r_state   <= ST_STOP;
                  r_txd     <= 1'b1;
`endif
               end else begin
                  r_bit_cnt <= CNT_MAX;
                  r_idx     <= r_idx + 3'd1;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_txd     <= r_shift[1];
               end
            end
            ST_PARITY: begin
               if (r_bit_cnt != {BW{1'b0}}) begin
                  r_bit_cnt <= r_bit_cnt - BW'(1);
               end else begin
                  r_bit_cnt <= CNT_MAX;
                  r_state   <= ST_STOP;
                  r_txd     <= 1'b1;
               end
            end
            ST_STOP: begin
               if (r_bit_cnt != {BW{1'b0}}) begin
                  r_bit_cnt <= r_bit_cnt - BW'(1);
               end else if (w_pop) begin
                  r_shift   <= w_head;
`ifdef UART_PARITY_EN
                  r_par     <= even_parity(w_head);
`endif
                  r_bit_cnt <= CNT_MAX;
                  r_state   <= ST_START;
                  r_txd     <= 1'b0;
               end else begin
                  r_state   <= ST_IDLE;
                  r_txd     <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
